// File: rtl/pe_layer_sequencer.sv
// ---------------------------------------------------------------------------
// pe_layer_sequencer
//
// Per-PE controller that walks the configured network one layer at a time.
// For every layer it issues one MAC op per (input activation, output
// activation) pair to the PE datapath. The output index is the outer loop and
// the input index is the inner loop. It then waits for the datapath write-back
// before it advances to the next layer.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   start        begin inference (sampled only while idle)
//   layer_no     number of weight layers (activation vectors 0..layer_no)
//   in_act_no    input activation count for the current layer_idx
//   out_act_no   output activation count for the current layer_idx
//   layer_idx    current layer, drives the PE state-register lookup
//   mac_valid    MAC op request
//   mac_ready    datapath accepts the op
//   in_idx       input activation index of the op
//   out_idx      output activation index of the op
//   last_in      op is the final input for out_idx (accumulator flush)
//   wb_done      datapath finished writing back the layer outputs
//   layer_done   one-cycle pulse when a layer completes its write-back
//   busy         high in every state except idle
//   done         one-cycle pulse at the end of inference
// ---------------------------------------------------------------------------
module pe_layer_sequencer #(
  parameter int LAYER_NO_WIDTH = 3,
  parameter int ACT_NO_WIDTH   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LAYER_NO_WIDTH-1:0] layer_no,
  input  logic [ACT_NO_WIDTH-1:0]   in_act_no,
  input  logic [ACT_NO_WIDTH-1:0]   out_act_no,
  output logic [LAYER_NO_WIDTH-1:0] layer_idx,
  output logic                      mac_valid,
  input  logic                      mac_ready,
  output logic [ACT_NO_WIDTH-1:0]   in_idx,
  output logic [ACT_NO_WIDTH-1:0]   out_idx,
  output logic                      last_in,
  input  logic                      wb_done,
  output logic                      layer_done,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_WB = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [ACT_NO_WIDTH-1:0]   ACT_ZERO   = {ACT_NO_WIDTH{1'b0}};
  localparam logic [ACT_NO_WIDTH-1:0]   ACT_ONE    = {{(ACT_NO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LAYER_NO_WIDTH-1:0] LAYER_ZERO = {LAYER_NO_WIDTH{1'b0}};
  localparam logic [LAYER_NO_WIDTH-1:0] LAYER_ONE  = {{(LAYER_NO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LAYER_NO_WIDTH:0]   LAYER_ONE_WIDE = {{LAYER_NO_WIDTH{1'b0}}, 1'b1};

  state_t                    state_r, state_s;
  logic [LAYER_NO_WIDTH-1:0] layer_idx_r, layer_idx_s;
  logic [ACT_NO_WIDTH-1:0]   in_idx_r, in_idx_s;
  logic [ACT_NO_WIDTH-1:0]   out_idx_r, out_idx_s;
  logic [ACT_NO_WIDTH-1:0]   n_in_r, n_in_s;
  logic [ACT_NO_WIDTH-1:0]   n_out_r, n_out_s;

  logic                      in_last_s;
  logic                      out_last_s;
  logic [LAYER_NO_WIDTH:0]   layer_step_s;
  logic                      layer_last_s;

  // Index/layer terminal-count decode. The layer compare is one bit wider so
  // that layer_no at its maximum value (layer_idx+1 overflowing) still ends.
  assign in_last_s    = (in_idx_r == (n_in_r - ACT_ONE));
  assign out_last_s   = (out_idx_r == (n_out_r - ACT_ONE));
  assign layer_step_s = {1'b0, layer_idx_r} + LAYER_ONE_WIDE;
  assign layer_last_s = (layer_step_s == {1'b0, layer_no});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: layer index, op indices and latched layer counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_idx_r <= LAYER_ZERO;
      in_idx_r    <= ACT_ZERO;
      out_idx_r   <= ACT_ZERO;
      n_in_r      <= ACT_ZERO;
      n_out_r     <= ACT_ZERO;
    end else begin
      layer_idx_r <= layer_idx_s;
      in_idx_r    <= in_idx_s;
      out_idx_r   <= out_idx_s;
      n_in_r      <= n_in_s;
      n_out_r     <= n_out_s;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_s     = state_r;
    layer_idx_s = layer_idx_r;
    in_idx_s    = in_idx_r;
    out_idx_s   = out_idx_r;
    n_in_s      = n_in_r;
    n_out_s     = n_out_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (layer_no != LAYER_ZERO) begin
            state_s     = ST_LOAD;
            layer_idx_s = LAYER_ZERO;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        // The count lookup is combinational on layer_idx, so the counts are
        // valid this cycle and can steer the empty-layer skip directly.
        n_in_s    = in_act_no;
        n_out_s   = out_act_no;
        in_idx_s  = ACT_ZERO;
        out_idx_s = ACT_ZERO;
        if ((in_act_no == ACT_ZERO) || (out_act_no == ACT_ZERO)) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (mac_ready) begin
          if (!in_last_s) begin
            in_idx_s = in_idx_r + ACT_ONE;
          end else begin
            in_idx_s  = ACT_ZERO;
            out_idx_s = out_idx_r + ACT_ONE;
            if (out_last_s) begin
              state_s = ST_WAIT_WB;
            end else begin
              state_s = ST_ISSUE;
            end
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end

      ST_WAIT_WB: begin
        if (wb_done) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_WAIT_WB;
        end
      end

      ST_NEXT: begin
        if (layer_last_s) begin
          state_s = ST_DONE;
        end else begin
          layer_idx_s = layer_idx_r + LAYER_ONE;
          state_s     = ST_LOAD;
        end
      end

      ST_DONE: begin
        state_s     = ST_IDLE;
        layer_idx_s = LAYER_ZERO;
      end

      default: begin
        state_s     = ST_IDLE;
        layer_idx_s = LAYER_ZERO;
        in_idx_s    = ACT_ZERO;
        out_idx_s   = ACT_ZERO;
      end
    endcase
  end

  // Outputs decode from registered state only; layer_done additionally gates
  // the incoming write-back strobe so it pulses in the cycle it is accepted.
  assign layer_idx  = layer_idx_r;
  assign in_idx     = in_idx_r;
  assign out_idx    = out_idx_r;
  assign mac_valid  = (state_r == ST_ISSUE);
  assign last_in    = (state_r == ST_ISSUE) && in_last_s;
  assign layer_done = (state_r == ST_WAIT_WB) && wb_done;
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);

endmodule

// File: tb/tb_pe_layer_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for pe_layer_sequencer. A reference model expands the configured
// network into the expected op list (layer, out, in, last) with nested loops.
// It also predicts the done cycle from per-layer costs. Stimulus randomizes
// backpressure, write-back delay and stray start/wb_done pulses.
// ---------------------------------------------------------------------------
module tb_pe_layer_sequencer;
  localparam int LW = 3;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] layer_no;
  logic [AW-1:0] in_act_no, out_act_no;
  logic [LW-1:0] layer_idx;
  logic          mac_valid, mac_ready;
  logic [AW-1:0] in_idx, out_idx;
  logic          last_in, wb_done, layer_done, busy, done;

  int acts [0:8];
  int vectors = 0;
  int miscompares = 0;

  typedef struct {int l; int o; int i; int last; int eol;} op_t;
  op_t exp_q[$];

  always #5 clk = ~clk;

  // State-register lookup model: counts of activation vectors idx and idx+1.
  assign in_act_no  = AW'(acts[int'(layer_idx)]);
  assign out_act_no = AW'(acts[int'(layer_idx) + 1]);

  pe_layer_sequencer #(.LAYER_NO_WIDTH(LW), .ACT_NO_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_no(layer_no),
    .in_act_no(in_act_no), .out_act_no(out_act_no), .layer_idx(layer_idx),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .in_idx(in_idx),
    .out_idx(out_idx), .last_in(last_in), .wb_done(wb_done),
    .layer_done(layer_done), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mac_valid"}, int'(mac_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_layer_done"}, int'(layer_done), 0);
    chk({tag, "_last_in"}, int'(last_in), 0);
    chk({tag, "_layer_idx"}, int'(layer_idx), 0);
    chk({tag, "_in_idx"}, int'(in_idx), 0);
    chk({tag, "_out_idx"}, int'(out_idx), 0);
  endtask

  task automatic set_acts(input int a0, input int a1, input int a2, input int a3);
    for (int k = 0; k < 9; k++) acts[k] = 0;
    acts[0] = a0; acts[1] = a1; acts[2] = a2; acts[3] = a3;
  endtask

  // One inference. ready_pct: chance of mac_ready per cycle; wbd: cycles from
  // ISSUE exit to the wb_done pulse; inject: stray start/wb_done during ISSUE;
  // abort_layer >= 0: assert rst while issuing on that layer and return.
  task automatic run(input int ln, input int ready_pct, input int wbd,
                     input bit inject, input int abort_layer);
    int  base, stalls, ld_exp, ld_seen, done_seen, wb_cnt, first_valid;
    int  nin, nout;
    bit  fin, pv, phs_eol, pstall, exp_ld, aborted;
    int  p_in, p_out;
    op_t e;

    exp_q.delete();
    layer_no = LW'(ln);
    base = 1; ld_exp = 0;
    for (int l = 0; l < ln; l++) begin
      nin = acts[l]; nout = acts[l + 1];
      base += 2;
      if (nin != 0 && nout != 0) begin
        base += nin * nout + wbd;
        ld_exp++;
        for (int o = 0; o < nout; o++)
          for (int i = 0; i < nin; i++)
            exp_q.push_back('{l, o, i, int'(i == nin - 1),
                              int'(o == nout - 1 && i == nin - 1)});
      end
    end

    stalls = 0; ld_seen = 0; done_seen = 0; wb_cnt = 0; first_valid = -1;
    fin = 0; pv = 0; phs_eol = 0; pstall = 0; aborted = 0; p_in = 0; p_out = 0;

    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      @(negedge clk);
      start   = (cyc == 0) || (inject && pv && ($urandom_range(0, 3) == 0));
      wb_done = 1'b0;
      exp_ld  = 1'b0;
      if (wb_cnt > 0) begin
        wb_cnt--;
        if (wb_cnt == 0) begin wb_done = 1'b1; exp_ld = 1'b1; end
      end else if (inject && pv && !phs_eol && ($urandom_range(0, 2) == 0)) begin
        wb_done = 1'b1;
      end
      mac_ready = ($urandom_range(1, 100) <= ready_pct);
      #1;

      if (done_seen != 0) begin
        chk("busy_after_done", int'(busy), 0);
        chk("layer_idx_after_done", int'(layer_idx), 0);
        chk("done_pulse_width", int'(done), 0);
        fin = 1;
      end else begin
        chk("busy", int'(busy), int'(cyc != 0));
        chk("layer_done", int'(layer_done), int'(exp_ld));
        ld_seen += int'(layer_done);
        if (pstall) begin
          chk("stall_valid_held", int'(mac_valid), 1);
          chk("stall_in_idx", int'(in_idx), p_in);
          chk("stall_out_idx", int'(out_idx), p_out);
        end
        phs_eol = 0;
        if (mac_valid) begin
          if (first_valid < 0) first_valid = cyc;
          if (mac_ready) begin
            if (exp_q.size() == 0) begin
              chk("extra_op", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("op_layer", int'(layer_idx), e.l);
              chk("op_out_idx", int'(out_idx), e.o);
              chk("op_in_idx", int'(in_idx), e.i);
              chk("op_last_in", int'(last_in), e.last);
              if (e.eol != 0) begin wb_cnt = wbd; phs_eol = 1; end
            end
          end else begin
            stalls++;
          end
        end
        pstall = mac_valid && !mac_ready;
        p_in   = int'(in_idx);
        p_out  = int'(out_idx);
        pv     = mac_valid;
        if (done) begin
          chk("done_cycle", cyc, base + stalls);
          chk("layer_idx_at_done", int'(layer_idx), (ln == 0) ? 0 : ln - 1);
          done_seen = 1;
        end
        if (abort_layer >= 0 && mac_valid && int'(layer_idx) == abort_layer) begin
          start = 1'b0; wb_done = 1'b0;
          #2 rst = 1'b1;
          #1 chk_all_zero("reset_async");
          @(negedge clk);
          chk_all_zero("reset_held");
          rst = 1'b0;
          aborted = 1; fin = 1;
        end
      end
    end

    if (!aborted) begin
      chk("run_completed", int'(fin), 1);
      chk("ops_remaining", exp_q.size(), 0);
      chk("layer_done_count", ld_seen, ld_exp);
      if (ln > 0 && acts[0] != 0 && acts[1] != 0) chk("first_valid_cycle", first_valid, 2);
      if (ld_exp == 0) chk("no_valid", first_valid, -1);
    end
    start = 1'b0; mac_ready = 1'b0; wb_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mac_ready = 1'b0; wb_done = 1'b0; layer_no = '0;
    for (int k = 0; k < 9; k++) acts[k] = 0;
    #1 chk_all_zero("reset_value");
    #20;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-layer run, ready tied high, write-back 2 cycles after ISSUE.
    set_acts(2, 3, 0, 0);
    run(1, 100, 2, 1'b0, -1);
    // Backpressure on the same configuration.
    run(1, 50, 2, 1'b0, -1);
    // Multi-layer: op counts 8, 10, 5.
    set_acts(4, 2, 5, 1);
    run(3, 100, 1, 1'b0, -1);
    run(3, 60, 3, 1'b0, -1);
    // Degenerate: no layers, then zero-count layers skipped.
    run(0, 100, 1, 1'b0, -1);
    set_acts(2, 0, 3, 2);
    run(3, 80, 2, 1'b0, -1);
    // Stray start and wb_done during ISSUE.
    set_acts(4, 2, 5, 1);
    run(3, 70, 2, 1'b1, -1);
    // Reset while issuing layer 1, then a full clean run.
    set_acts(2, 3, 2, 0);
    run(2, 100, 2, 1'b0, 1);
    run(2, 70, 2, 1'b0, -1);
    // Maximum layer count and maximum activation count.
    for (int k = 0; k < 9; k++) acts[k] = 1 + (k % 2);
    run(7, 100, 1, 1'b0, -1);
    set_acts(63, 1, 0, 0);
    run(1, 90, 1, 1'b0, -1);
    // Randomized configurations.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 9; k++) acts[k] = $urandom_range(0, 5);
      run($urandom_range(1, 7), $urandom_range(30, 100), $urandom_range(1, 3), 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
